// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving a 16-bit universal shift register: load, shift right/left N, hold N.
// Define USR_SEQ_ROTATE_EN to feed q_in back as serial fill when a rotate is requested.
module usr_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] d,
    output logic             sin_left,
    output logic             sin_right,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_SR   = 2'b01;
    localparam logic [1:0] OP_SL   = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, eff_cnt;
    logic [1:0]       mode_nx;
    logic [WIDTH-1:0] d_nx;
    logic             sl_q, sl_nx, sr_q, sr_nx;
    logic             busy_nx, done_nx, ready_nx;
    logic             fill_eff;

    // rotate-only bits of the inputs are otherwise unobserved
    logic unused;
    assign unused = ^{q_in, cmd_rot};

`ifdef USR_SEQ_ROTATE_EN
    logic rot_q, rot_nx;
    // a rotating shift takes its fill live from q_in, so the registered fill stays 0
    assign fill_eff  = cmd_fill & ~cmd_rot;
    assign sin_left  = (rot_q && state == RUN && mode == OP_SR) ? q_in[0]       : sl_q;
    assign sin_right = (rot_q && state == RUN && mode == OP_SL) ? q_in[WIDTH-1] : sr_q;
`else
    assign fill_eff  = cmd_fill;
    assign sin_left  = sl_q;
    assign sin_right = sr_q;
`endif

    assign eff_cnt = (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_count;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;
        d_nx     = d;
        sl_nx    = sl_q;
        sr_nx    = sr_q;
        busy_nx  = busy;
        done_nx  = done;
        ready_nx = cmd_ready;
`ifdef USR_SEQ_ROTATE_EN
        rot_nx   = rot_q;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    ready_nx = 1'b0;
                    busy_nx  = 1'b1;
                    cnt_nx   = eff_cnt;
`ifdef USR_SEQ_ROTATE_EN
                    rot_nx   = cmd_rot;
`endif
                    if (cmd_op == OP_LOAD)
                        d_nx = cmd_data;
                    if (eff_cnt == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RUN;
                        mode_nx  = cmd_op;
                        sl_nx    = (cmd_op == OP_SR) & fill_eff;
                        sr_nx    = (cmd_op == OP_SL) & fill_eff;
                    end
                end else begin
                    ready_nx = 1'b1;
                end
            end
            RUN: begin
                cnt_nx = cnt - CNT_W'(1);
                // last active cycle: the register samples mode once more on this edge
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                    mode_nx  = 2'b00;
                    sl_nx    = 1'b0;
                    sr_nx    = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                done_nx  = 1'b0;
                busy_nx  = 1'b0;
                ready_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 2'b00;
            d         <= '0;
            sl_q      <= 1'b0;
            sr_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mode      <= mode_nx;
            d         <= d_nx;
            sl_q      <= sl_nx;
            sr_q      <= sr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            cmd_ready <= ready_nx;
`ifdef USR_SEQ_ROTATE_EN
            rot_q     <= rot_nx;
`endif
        end
    end
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: drives a behavioural 16-bit universal shift register and checks
// every cycle against a timeline model of each accepted command, plus literal end values.
module tb_usr_cmd_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, sr_rst;
    logic             cmd_valid, cmd_ready, cmd_fill, cmd_rot;
    logic [1:0]       cmd_op, mode;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data, d, q;
    logic             sin_left, sin_right, busy, done;

    int checks = 0, errors = 0;
    int mode_cyc = 0, done_cyc = 0, acc_cyc = 0;

    always #5 clk = ~clk;

    usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .cmd_fill(cmd_fill), .cmd_rot(cmd_rot), .q_in(q), .mode(mode), .d(d),
        .sin_left(sin_left), .sin_right(sin_right), .busy(busy), .done(done)
    );

    // universal shift register: 00 hold, 01 right (sin_left -> MSB), 10 left (sin_right -> LSB), 11 load
    always @(posedge clk) begin
        if (sr_rst) q <= '0;
        else case (mode)
            2'b01:   q <= {sin_left, q[WIDTH-1:1]};
            2'b10:   q <= {q[WIDTH-2:0], sin_right};
            2'b11:   q <= d;
            default: q <= q;
        endcase
    end

    // model: k = edges elapsed since the accepting edge; command occupies k = 1 .. C+1
    bit               act = 1'b0, rdy_m = 1'b0;
    int               k = 0, c = 0;
    logic [1:0]       m_op = 2'b00;
    logic             m_fill = 1'b0, m_rot = 1'b0;
    logic [WIDTH-1:0] d_m = '0;

    always @(posedge clk) begin
        if (!rst) begin
            act = 1'b0; rdy_m = 1'b0; d_m = '0;
        end else if (act) begin
            if (k == c + 1) begin act = 1'b0; rdy_m = 1'b1; end
            else k++;
        end else if (rdy_m && cmd_valid) begin
            act = 1'b1; k = 1; rdy_m = 1'b0;
            m_op = cmd_op; m_fill = cmd_fill; m_rot = cmd_rot;
            c = (cmd_op == 2'b11) ? 1 : int'(cmd_count);
            if (cmd_op == 2'b11) d_m = cmd_data;
        end else begin
            rdy_m = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t actual=%0h required=%0h", nm, $time, a, e);
        end
    endtask

    // one cycle: compare at the falling edge, then advance past the next rising edge
    task automatic tick();
        logic [1:0] mode_e;
        logic       run_e, sl_e, sr_e;
        @(negedge clk);
        run_e  = act && (k <= c);
        mode_e = run_e ? m_op : 2'b00;
        sl_e   = (run_e && m_op == 2'b01) ? ((ROT && m_rot) ? q[0] : m_fill) : 1'b0;
        sr_e   = (run_e && m_op == 2'b10) ? ((ROT && m_rot) ? q[WIDTH-1] : m_fill) : 1'b0;
        chk("mode", 32'(mode), 32'(mode_e));
        chk("d", 32'(d), 32'(d_m));
        chk("busy", 32'(busy), 32'(act));
        chk("done", 32'(done), 32'(act && k == c + 1));
        chk("cmd_ready", 32'(cmd_ready), 32'(rdy_m));
        chk("sin_left", 32'(sin_left), 32'(sl_e));
        chk("sin_right", 32'(sin_right), 32'(sr_e));
        if (mode != 2'b00) mode_cyc++;
        if (done) done_cyc++;
        if (cmd_valid && cmd_ready) acc_cyc++;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] op, input int cnt, input logic [15:0] data,
                         input logic fill, input logic rot);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = CNT_W'(cnt);
        cmd_data = data; cmd_fill = fill; cmd_rot = rot;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        if (n == 50) chk("accept_timeout", 32'(n), 32'(0));
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 60) begin tick(); n++; end
        if (n == 60) chk("idle_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        int m0, d0, a0;
        logic [15:0] q0;
        rst = 1'b0; sr_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
        cmd_data = '0; cmd_fill = 1'b0; cmd_rot = 1'b0;

        // reset for two edges
        @(posedge clk); #1;
        tick();
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_d", 32'(d), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sin", 32'({sin_left, sin_right}), 32'h0);
        rst = 1'b1; sr_rst = 1'b0;
        tick();
        chk("ready_after_release", 32'(cmd_ready), 32'h1);

        // load A5A5
        m0 = mode_cyc; d0 = done_cyc;
        issue(2'b11, 7, 16'hA5A5, 1'b0, 1'b0);
        wait_idle();
        chk("load_q", 32'(q), 32'hA5A5);
        chk("load_mode_cycles", 32'(mode_cyc - m0), 32'd1);
        chk("load_done_pulses", 32'(done_cyc - d0), 32'd1);

        // shift right 2 fill 1, then shift left 2 fill 1
        m0 = mode_cyc; d0 = done_cyc;
        issue(2'b01, 2, 16'h0, 1'b1, 1'b0);
        wait_idle();
        chk("sr2_q", 32'(q), 32'hE969);
        chk("sr2_mode_cycles", 32'(mode_cyc - m0), 32'd2);
        chk("sr2_done_pulses", 32'(done_cyc - d0), 32'd1);
        issue(2'b10, 2, 16'h0, 1'b1, 1'b0);
        wait_idle();
        chk("sl2_q", 32'(q), 32'hA5A7);

        // count 0 with valid held high for six cycles: accept every other cycle
        m0 = mode_cyc; d0 = done_cyc; a0 = acc_cyc; q0 = q;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = '0; cmd_fill = 1'b1;
        repeat (6) tick();
        cmd_valid = 1'b0;
        chk("c0_accepts", 32'(acc_cyc - a0), 32'd3);
        chk("c0_done_pulses", 32'(done_cyc - d0), 32'd3);
        chk("c0_mode_cycles", 32'(mode_cyc - m0), 32'd0);
        chk("c0_q", 32'(q), 32'(q0));

        // hold for the maximum count: pure delay
        m0 = mode_cyc; d0 = done_cyc;
        issue(2'b00, 31, 16'h0, 1'b1, 1'b0);
        wait_idle();
        chk("hold31_q", 32'(q), 32'hA5A7);
        chk("hold31_mode_cycles", 32'(mode_cyc - m0), 32'd0);
        chk("hold31_done_pulses", 32'(done_cyc - d0), 32'd1);

        // shift left 10, reset lands on the third shift edge
        d0 = done_cyc;
        issue(2'b10, 10, 16'h0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("abort_q", 32'(q), 32'h2D38);
        chk("abort_mode", 32'(mode), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h0);
        chk("abort_d", 32'(d), 32'h0);
        tick();
        rst = 1'b1;
        wait_idle();
        chk("abort_done_pulses", 32'(done_cyc - d0), 32'd0);
        chk("abort_ready_back", 32'(cmd_ready), 32'h1);

        // rotate right by one from 8001
        issue(2'b11, 0, 16'h8001, 1'b0, 1'b0);
        wait_idle();
        issue(2'b01, 1, 16'h0, 1'b0, 1'b1);
        wait_idle();
        chk("rotate_q", 32'(q), ROT ? 32'hC000 : 32'h4000);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Command-driven sequencer that sits directly upstream of the 16-bit universal shift register (`universal_shift_reg16`) and drives its `mode`, `d`, `sin_left` and `sin_right` inputs. It accepts one command at a time over a valid/ready handshake: load, shift right N, shift left N, or hold N. It then issues the exact per-cycle mode sequence and pulses `done` when the sequence is finished. Its purpose is to let higher-level control issue multi-bit shift operations without cycle-counting mode changes itself.

## Interface
- `WIDTH`, 16, data width; matches the shift register width.
- `CNT_W`, 5, width of the shift/hold count; the maximum count is 2^CNT_W-1.

- `clk` input 1: rising-edge clock, shared with the shift register.
- `rst` input 1: synchronous active-low reset; sampled on the `clk` rising edge only.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the sequencer can accept a command. Registered.
- `cmd_op` input 2: operation code.
  - 00 = hold/delay
  - 01 = shift right
  - 10 = shift left
  - 11 = parallel load
- `cmd_count` input CNT_W: number of shift or hold cycles. Ignored for load.
- `cmd_data` input WIDTH: load value. Used only when op = 11.
- `cmd_fill` input 1: serial fill bit for shift operations.
- `cmd_rot` input 1: rotate request. Used only when `USR_SEQ_ROTATE_EN` is defined.
- `q_in` input WIDTH: shift register output, fed back for rotate.
- `mode` output 2: drives the shift register `mode` input. Registered.
- `d` output WIDTH: drives the shift register `d` input. Registered.
- `sin_left` output 1: serial input entering the MSB on a right shift.
- `sin_right` output 1: serial input entering the LSB on a left shift.
- `busy` output 1: a command is in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst`=0 at an edge):
  - state goes to IDLE.
  - `mode`=00, `d`=0, `sin_left`=0, `sin_right`=0, `busy`=0, `done`=0, `cmd_ready`=0, internal counter = 0.
  - `cmd_ready` rises on the first edge with `rst`=1.
- Accept: a command is accepted when `cmd_valid` and `cmd_ready` are both high at an edge (call it E0). Only possible in IDLE.
- At E0:
  - `cmd_op`, `cmd_count`, `cmd_fill` and `cmd_rot` are latched.
  - `cmd_ready` goes to 0 and `busy` goes to 1.
  - For op 11, `d` is loaded with `cmd_data`. `d` is otherwise unchanged.
- Effective count C:
  - op 11: C = 1.
  - other ops: C = `cmd_count`.
- C = 0: go to DONE directly; `mode` stays 00.
- C > 0: go to RUN; `mode` = op; counter = C.
- RUN:
  - Each edge decrements the counter.
  - On the edge where the counter reaches 0, `mode` goes to 00 and the state goes to DONE with `done`=1.
  - This gives exactly C shift-register edges with `mode` = op.
- DONE:
  - Lasts one cycle, with `done`=1 and `busy`=1.
  - On the next edge: `done`=0, `busy`=0, `cmd_ready`=1, state goes to IDLE.
- Fill bits:
  - During op 01, `sin_left` = latched fill.
  - During op 10, `sin_right` = latched fill.
  - Both are 0 in every other state and op.
- `cmd_valid` while busy is ignored. No queuing; the upstream side must hold the command until `cmd_ready`.
- Reset mid-RUN aborts immediately to reset values. There is no `done` pulse, and the partial shifts already applied stand.
- Hold op with C > 0 behaves as a C-cycle delay with `mode`=00.

## Timing
- Accept at E0 gives:
  - `mode` active during the cycles after E0 .. E(C-1).
  - the shift register samples `mode` at E1..EC.
  - `done` high during the cycle after EC.
  - `cmd_ready` high after E(C+1).
- The earliest next accept is E(C+2). Command throughput is C+2 cycles; for C=0 it is 2 cycles.
- `mode`, `d`, `busy`, `done` and `cmd_ready` are all registered. `sin_left` and `sin_right` are registered except in rotate (see below).
- On reset release, `cmd_ready` is 1 one cycle after the first edge with `rst`=1.

## Configuration
- `USR_SEQ_ROTATE_EN` defined:
  - if latched `cmd_rot`=1 during op 01, `sin_left` = `q_in[0]` (combinational from `q_in`).
  - if latched `cmd_rot`=1 during op 10, `sin_right` = `q_in[WIDTH-1]` (combinational from `q_in`).
  - this gives a true rotate; `cmd_fill` is ignored when rotating.
- Not defined:
  - `cmd_rot` and `q_in` are ignored; fill always comes from `cmd_fill`.
  - the ports remain present.

## Test plan
The bench instantiates the sequencer driving `universal_shift_reg16`. The register's active-high reset is driven separately.

1. Reset: `rst`=0 for 2 cycles -> `mode`=00, `d`=0000, `sin_*`=0, `done`=0, `cmd_ready`=0; `cmd_ready`=1 one cycle after release.
2. Load: op 11, data A5A5 -> `mode`=11 for exactly 1 cycle, `done` pulse 1 cycle later, `q`=A5A5.
3. Shift right: op 01, count 2, fill 1 (from A5A5) -> `mode`=01 for exactly 2 cycles, `q`=E969, then op 10, count 2, fill 1 -> `q`=A5A7. Check `done` timing and that `cmd_ready` is low throughout.
4. Count 0: op 01, count 0 -> `done` the cycle after accept, `mode` never leaves 00, `q` unchanged. Hold `cmd_valid` high while busy -> exactly one accept per `cmd_ready` window.
5. Reset mid-operation: op 10, count 10, `rst`=0 after 3 shifts -> outputs at reset values, no `done` pulse, `q` reflects 3 shifts, `cmd_ready` returns after release.
6. Rotate: load 8001, op 01, count 1, `cmd_rot`=1, fill 0 -> `q`=C000 with `USR_SEQ_ROTATE_EN` defined; `q`=4000 without it.
